// File: rtl/alarm_clock_gen2_if.sv
// Switch and display bundle for alarm_clock_gen2.
// The slave side (clock core) receives the three raw push-buttons and drives
// the time, alarm, mode and buzzer signals. The master side is the board or
// bench: it drives the buttons and observes everything else.
//   switch_1/2/3   raw active-high buttons (mode/dismiss, increment, alarm/snooze)
//   hours/minutes/seconds           current time
//   disp_hours/pm                   hour as shown on the display, pm flag
//   alarm_hours/alarm_minutes/alarm_en  alarm setting and arm state
//   mode                            0 RUN .. 4 ALM_MIN
//   buzzer                          high while ringing
interface alarm_clock_gen2_if;
  logic       switch_1;
  logic       switch_2;
  logic       switch_3;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [4:0] disp_hours;
  logic       pm;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       alarm_en;
  logic [2:0] mode;
  logic       buzzer;

  modport master (
    output switch_1, switch_2, switch_3,
    input  hours, minutes, seconds, disp_hours, pm,
    input  alarm_hours, alarm_minutes, alarm_en, mode, buzzer
  );

  modport slave (
    input  switch_1, switch_2, switch_3,
    output hours, minutes, seconds, disp_hours, pm,
    output alarm_hours, alarm_minutes, alarm_en, mode, buzzer
  );
endinterface

// File: rtl/alarm_clock_gen2.sv
// Digital clock with alarm, setting modes, 12/24-hour display, snooze and
// dismiss.
// Ports:
//   clk   system clock, TICKS_PER_SEC cycles per second
//   rst   asynchronous active-high reset
//   bus   alarm_clock_gen2_if.slave: raw buttons in; time, display, alarm,
//         mode and buzzer out
// Each button passes a 2-FF synchroniser and a debouncer; an accepted 0->1
// level change yields a one-cycle press pulse that the mode FSM acts on in
// the following cycle.
module alarm_clock_gen2 #(
  parameter int unsigned TICKS_PER_SEC   = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned BUZZ_SECONDS    = 60,
  parameter int unsigned SNOOZE_MINUTES  = 5,
  parameter bit          HOUR_MODE_24    = 1'b1
) (
  input logic              clk,
  input logic              rst,
  alarm_clock_gen2_if.slave bus
);

  localparam int unsigned     TW          = $clog2(TICKS_PER_SEC);
  localparam int unsigned     DW          = $clog2(DEBOUNCE_CYCLES + 1);
  localparam longint unsigned RING_CYCLES = longint'(BUZZ_SECONDS) * longint'(TICKS_PER_SEC);
  localparam int unsigned     RW          = $clog2(RING_CYCLES);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    SET_HOUR = 3'd1,
    SET_MIN  = 3'd2,
    ALM_HOUR = 3'd3,
    ALM_MIN  = 3'd4
  } mode_t;

  // ---------------------------------------------------------------- switches
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    level;
  logic [2:0]    press;
  logic [DW-1:0] db_cnt [3];

  assign raw = {bus.switch_3, bus.switch_2, bus.switch_1};

  // db_cnt counts consecutive samples that disagree with the accepted level;
  // any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      press <= '0;
      for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  logic p1, p2, p3;
  assign p1 = press[0];
  assign p2 = press[1];
  assign p3 = press[2];

  // ------------------------------------------------------------- core state
  mode_t         state;
  logic [TW-1:0] tick;
  logic [4:0]    hours;
  logic [5:0]    minutes;
  logic [5:0]    seconds;
  logic [4:0]    alarm_h;
  logic [5:0]    alarm_m;
  logic          alarm_en;
  logic          buzzer;
  logic [RW-1:0] ring_cnt;
  logic          snz_pend;
  logic [4:0]    snz_h;
  logic [5:0]    snz_m;

  function automatic logic [4:0] inc_hour(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_min(input logic [5:0] m);
    return (m == 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  logic       running;
  logic       sec_tick;
  logic [5:0] nxt_s;
  logic [5:0] nxt_m;
  logic [4:0] nxt_h;
  logic [6:0] snz_sum;
  logic [5:0] snz_m_new;
  logic [4:0] snz_h_new;
  logic       snooze_hit;
  logic       alarm_hit;

  assign running  = (state != SET_HOUR) && (state != SET_MIN);
  assign sec_tick = running && (tick == TW'(TICKS_PER_SEC - 1));

  always_comb begin
    nxt_s = inc_min(seconds);
    nxt_m = minutes;
    nxt_h = hours;
    if (seconds == 6'd59) begin
      nxt_m = inc_min(minutes);
      if (minutes == 6'd59) nxt_h = inc_hour(hours);
    end
  end

  // Snooze target is the current hh:mm plus SNOOZE_MINUTES, wrapping hours.
  always_comb begin
    snz_sum   = {1'b0, minutes} + 7'(SNOOZE_MINUTES);
    snz_m_new = snz_sum[5:0];
    snz_h_new = hours;
    if (snz_sum >= 7'd60) begin
      snz_m_new = 6'(snz_sum - 7'd60);
      snz_h_new = inc_hour(hours);
    end
  end

  // Triggers look at the time that this sec_tick is about to load.
  assign snooze_hit = snz_pend && (nxt_h == snz_h) && (nxt_m == snz_m);
  assign alarm_hit  = (state == RUN) && alarm_en && sec_tick && (nxt_s == 6'd0) &&
                      (((nxt_h == alarm_h) && (nxt_m == alarm_m)) || snooze_hit);

  // Later assignments take priority: timekeeping, then ring countdown, then
  // alarm trigger, then button actions (which may cancel a same-cycle ring).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      tick     <= '0;
      hours    <= '0;
      minutes  <= '0;
      seconds  <= '0;
      alarm_h  <= '0;
      alarm_m  <= '0;
      alarm_en <= 1'b0;
      buzzer   <= 1'b0;
      ring_cnt <= '0;
      snz_pend <= 1'b0;
      snz_h    <= '0;
      snz_m    <= '0;
    end else begin
      if (running) begin
        if (sec_tick) begin
          tick    <= '0;
          seconds <= nxt_s;
          minutes <= nxt_m;
          hours   <= nxt_h;
        end else begin
          tick <= tick + TW'(1);
        end
      end

      if (buzzer) begin
        if (ring_cnt == RW'(RING_CYCLES - 1)) buzzer <= 1'b0;
        else ring_cnt <= ring_cnt + RW'(1);
      end

      if (alarm_hit) begin
        buzzer   <= 1'b1;
        ring_cnt <= '0;
        if (snooze_hit) snz_pend <= 1'b0;
      end

      case (state)
        RUN: begin
          if (buzzer) begin
            if (p1) begin
              buzzer   <= 1'b0;
              snz_pend <= 1'b0;
            end else if (p3) begin
              buzzer   <= 1'b0;
              snz_pend <= 1'b1;
              snz_h    <= snz_h_new;
              snz_m    <= snz_m_new;
            end
          end else if (p1) begin
            state   <= SET_HOUR;
            seconds <= '0;
            tick    <= '0;
            buzzer  <= 1'b0;
          end else if (p3) begin
            alarm_en <= ~alarm_en;
            if (alarm_en) snz_pend <= 1'b0;
          end
        end
        SET_HOUR: begin
          if (p1) state <= SET_MIN;
          else if (p2) hours <= inc_hour(hours);
        end
        SET_MIN: begin
          if (p1) state <= ALM_HOUR;
          else if (p2) minutes <= inc_min(minutes);
        end
        ALM_HOUR: begin
          if (p1) state <= ALM_MIN;
          else if (p2) alarm_h <= inc_hour(alarm_h);
        end
        ALM_MIN: begin
          if (p1) state <= RUN;
          else if (p2) alarm_m <= inc_min(alarm_m);
        end
        default: state <= RUN;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  logic [4:0] disp;

  always_comb begin
    disp = hours;
    if (!HOUR_MODE_24) begin
      if (hours == 5'd0)      disp = 5'd12;
      else if (hours > 5'd12) disp = hours - 5'd12;
    end
  end

  assign bus.hours         = hours;
  assign bus.minutes       = minutes;
  assign bus.seconds       = seconds;
  assign bus.disp_hours    = disp;
  assign bus.pm            = (hours >= 5'd12);
  assign bus.alarm_hours   = alarm_h;
  assign bus.alarm_minutes = alarm_m;
  assign bus.alarm_en      = alarm_en;
  assign bus.mode          = state;
  assign bus.buzzer        = buzzer;

endmodule
